// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
//  muldiv_unit_pkg
//  Shared RV32M funct3 codes, state encodings and constants for muldiv_unit.
//  Revision: 1.0
// ============================================================================
package muldiv_unit_pkg;

    localparam int N     = 32;
    localparam int CNT_W = $clog2(N);

    localparam logic [N-1:0] ZERO = '0;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_CALC = 1'b1
    } md_state_t;

    function automatic logic a_is_signed(input logic [2:0] op);
        return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] op);
        return (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
//  muldiv_unit_if
//  Request/response bundle between the EX stage and muldiv_unit.
//  Revision: 1.0
// ============================================================================
interface muldiv_unit_if;
    import muldiv_unit_pkg::*;

    logic         start;
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic [N-1:0] result;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_iter_step.sv
`default_nettype none
// ============================================================================
//  muldiv_iter_step
//  One iteration: shift-add multiply step or restoring divide step.
//  Revision: 1.0
// ============================================================================
module muldiv_iter_step #(
    parameter int N = 32
) (
    input  wire logic           i_is_div,
    input  wire logic [2*N-1:0] i_acc,
    input  wire logic [N-1:0]   i_opnd,
    output logic      [2*N-1:0] o_acc
);

    logic [N:0] w_sum;
    logic [N:0] w_rem_sh;
    logic [N:0] w_trial;

    // Multiply: acc = {partial hi, multiplier lo}; divide: acc = {remainder, dividend/quotient}.
    always_comb begin
        w_sum    = {1'b0, i_acc[2*N-1:N]} + (i_acc[0] ? {1'b0, i_opnd} : {(N+1){1'b0}});
        w_rem_sh = i_acc[2*N-1:N-1];
        w_trial  = w_rem_sh - {1'b0, i_opnd};
        if (!i_is_div)
            o_acc = {w_sum, i_acc[N-1:1]};
        else if (!w_trial[N])
            o_acc = {w_trial[N-1:0], i_acc[N-2:0], 1'b1};
        else
            o_acc = {w_rem_sh[N-1:0], i_acc[N-2:0], 1'b0};
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  muldiv_unit
//  Iterative RV32M multiply/divide; MULDIV_FAST_MUL_EN selects a one-cycle multiply.
//  Revision: 1.0
// ============================================================================
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      rst_n,
    muldiv_unit_if.slave   bus
);

    md_state_t      r_state;
    logic           r_busy;
    logic           r_done;
    logic [N-1:0]   r_result;
    logic [CNT_W-1:0] r_cnt;
    logic [2*N-1:0] r_acc;
    logic [N-1:0]   r_opnd;
    logic [2:0]     r_op;
    logic           r_qneg;
    logic           r_rneg;

    logic           w_a_neg;
    logic           w_b_neg;
    logic [N-1:0]   w_abs_a;
    logic [N-1:0]   w_abs_b;
    logic           w_fast;
    logic [N-1:0]   w_fast_result;
    logic [2*N-1:0] w_acc_next;
    logic [2*N-1:0] w_prod;
    logic [N-1:0]   w_quo;
    logic [N-1:0]   w_rem;
    logic [N-1:0]   w_final;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*N-1:0] w_fast_prod;
`endif

    always_comb begin
        w_a_neg = a_is_signed(bus.op) & bus.a[N-1];
        w_b_neg = b_is_signed(bus.op) & bus.b[N-1];
        w_abs_a = w_a_neg ? -bus.a : bus.a;
        w_abs_b = w_b_neg ? -bus.b : bus.b;
    end

    // Cases resolved at accept time without entering CALC.
    always_comb begin
        w_fast        = 1'b0;
        w_fast_result = ZERO;
`ifdef MULDIV_FAST_MUL_EN
        w_fast_prod   = {ZERO, w_abs_a} * {ZERO, w_abs_b};
        if (w_a_neg ^ w_b_neg)
            w_fast_prod = -w_fast_prod;
`endif
        if (bus.op[2] && (bus.b == ZERO)) begin
            w_fast        = 1'b1;
            w_fast_result = bus.op[1] ? bus.a : {N{1'b1}};
        end else if (((bus.op == DIV) || (bus.op == REM)) &&
                     (bus.a == {1'b1, {(N-1){1'b0}}}) && (bus.b == {N{1'b1}})) begin
            w_fast        = 1'b1;
            w_fast_result = bus.op[1] ? ZERO : {1'b1, {(N-1){1'b0}}};
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (!bus.op[2]) begin
            w_fast        = 1'b1;
            w_fast_result = (bus.op == MUL) ? w_fast_prod[N-1:0] : w_fast_prod[2*N-1:N];
        end
`endif
    end

    muldiv_iter_step #(.N(N)) u_step (
        .i_is_div (r_op[2]),
        .i_acc    (r_acc),
        .i_opnd   (r_opnd),
        .o_acc    (w_acc_next)
    );

    // Sign fix-up applied to the value produced by the final iteration.
    always_comb begin
        w_prod = r_qneg ? -w_acc_next : w_acc_next;
        w_quo  = r_qneg ? -w_acc_next[N-1:0] : w_acc_next[N-1:0];
        w_rem  = r_rneg ? -w_acc_next[2*N-1:N] : w_acc_next[2*N-1:N];
        if (!r_op[2])
            w_final = (r_op == MUL) ? w_prod[N-1:0] : w_prod[2*N-1:N];
        else
            w_final = r_op[1] ? w_rem : w_quo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= MD_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= ZERO;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= ZERO;
            r_op     <= MUL;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.flush) begin
                r_state <= MD_IDLE;
                r_busy  <= 1'b0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    MD_IDLE: begin
                        if (bus.start) begin
                            r_op   <= bus.op;
                            r_qneg <= w_a_neg ^ w_b_neg;
                            r_rneg <= w_a_neg;
                            if (w_fast) begin
                                r_done   <= 1'b1;
                                r_result <= w_fast_result;
                            end else begin
                                r_state <= MD_CALC;
                                r_busy  <= 1'b1;
                                r_cnt   <= CNT_W'(N-1);
                                r_acc   <= bus.op[2] ? {ZERO, w_abs_a} : {ZERO, w_abs_b};
                                r_opnd  <= bus.op[2] ? w_abs_b : w_abs_a;
                            end
                        end
                    end
                    MD_CALC: begin
                        r_acc <= w_acc_next;
                        if (r_cnt == '0) begin
                            r_state  <= MD_IDLE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_result <= w_final;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    default: begin
                        r_state <= MD_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  tb_muldiv_unit
//  Directed self-checking bench for muldiv_unit.
//  Revision: 1.0
// ============================================================================
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic saw_done;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues op in the current cycle (cycle 0) and checks the full response timing.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit fast);
        logic bad_busy;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (!fast) begin
            bad_busy = 1'b0;
            for (int c = 1; c <= N; c++) begin
                if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad_busy = 1'b1;
                @(posedge clk); #1;
            end
            chk({tag, "_busy_window"}, {31'b0, bad_busy}, 32'd0);
        end
        chk({tag, "_busy_done"}, {30'b0, bus.busy, bus.done}, 32'd1);
        chk({tag, "_result"}, bus.result, exp);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = MUL;
        bus.a     = '0;
        bus.b     = '0;

        #2;
        chk("reset_busy_done", {30'b0, bus.busy, bus.done}, 32'd0);
        chk("reset_result", bus.result, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("mul", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, FAST_MUL);
        @(posedge clk); #1;
        chk("mul_done_pulse_end", {30'b0, bus.busy, bus.done}, 32'd0);

        run_op("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, FAST_MUL);
        run_op("mulh", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, FAST_MUL);
        run_op("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, FAST_MUL);
        run_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        run_op("rem_neg", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        run_op("divu", DIVU, 32'd100, 32'd7, 32'h0000_000E, 1'b0);
        run_op("remu", REMU, 32'd100, 32'd7, 32'h0000_0002, 1'b0);
        run_op("mul_6x7", MUL, 32'd6, 32'd7, 32'd42, FAST_MUL);
        @(posedge clk); #1;

        run_op("rem_by0", REM, 32'd5, 32'd0, 32'd5, 1'b1);
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        run_op("divu_by0", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
        @(posedge clk); #1;
        chk("fast_done_pulse_end", {30'b0, bus.busy, bus.done}, 32'd0);

        // Flush in cycle 10 of a DIV.
        bus.start = 1'b1;
        bus.op    = DIV;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        chk("flush_c10_busy", {31'b0, bus.busy}, 32'd1);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_c11_busy_done", {30'b0, bus.busy, bus.done}, 32'd0);
        chk("flush_result_held", bus.result, 32'hFFFF_FFFF);
        saw_done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        chk("flush_no_done", {31'b0, saw_done}, 32'd0);

        // Flush and start together: start dropped.
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = MUL;
        bus.a     = 32'd3;
        bus.b     = 32'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("flush_start_dropped", {30'b0, bus.busy, bus.done}, 32'd0);

        run_op("mul_3x4", MUL, 32'd3, 32'd4, 32'd12, FAST_MUL);
        run_op("b2b_divu", DIVU, 32'd100, 32'd7, 32'h0000_000E, 1'b0);
        @(posedge clk); #1;

        // Asynchronous reset in cycle 5 of a DIVU.
        bus.start = 1'b1;
        bus.op    = DIVU;
        bus.a     = 32'd1000;
        bus.b     = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("rst_c5_busy", {31'b0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_busy_done", {30'b0, bus.busy, bus.done}, 32'd0);
        chk("rst_async_result", bus.result, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        chk("rst_no_done", {31'b0, saw_done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
